// File: rtl/nmr_pll_reconfig_seq.sv
`default_nettype none
// ============================================================================
// Module   : nmr_pll_reconfig_seq
// Brief    : Replays an M/C0 counter setting into altera_pll_reconfig over
//            Avalon-MM, polls for completion and qualifies a stable PLL lock.
// Revision : 1.0  initial release
// ============================================================================
module nmr_pll_reconfig_seq #(
    parameter int LOCK_TIMEOUT = 100000,
    parameter int LOCK_STABLE  = 64,
    parameter int POLL_LIMIT   = 4096
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [7:0]  cfg_m_hi,
    input  logic [7:0]  cfg_m_lo,
    input  logic        cfg_m_odd,
    input  logic [7:0]  cfg_c0_hi,
    input  logic [7:0]  cfg_c0_lo,
    input  logic        cfg_c0_odd,
    input  logic        pll_locked,
    output logic [5:0]  mgmt_address,
    output logic        mgmt_write,
    output logic        mgmt_read,
    output logic [31:0] mgmt_writedata,
    input  logic [31:0] mgmt_readdata,
    input  logic        mgmt_waitrequest,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [1:0]  err_code
);

    localparam logic [3:0] c_idle      = 4'd0;
    localparam logic [3:0] c_check     = 4'd1;
    localparam logic [3:0] c_wr_mode   = 4'd2;
    localparam logic [3:0] c_wr_m      = 4'd3;
    localparam logic [3:0] c_wr_c      = 4'd4;
    localparam logic [3:0] c_wr_start  = 4'd5;
    localparam logic [3:0] c_poll_rd   = 4'd6;
    localparam logic [3:0] c_lock_wait = 4'd7;
    localparam logic [3:0] c_done      = 4'd8;
    localparam logic [3:0] c_err       = 4'd9;

    localparam int c_tmo_w  = $clog2(LOCK_TIMEOUT + 1);
    localparam int c_stb_w  = $clog2(LOCK_STABLE + 1);
    localparam int c_poll_w = $clog2(POLL_LIMIT + 1);
    localparam logic [c_tmo_w-1:0]  c_tmo_tgt  = c_tmo_w'(LOCK_TIMEOUT);
    localparam logic [c_stb_w-1:0]  c_stb_tgt  = c_stb_w'(LOCK_STABLE);
    localparam logic [c_poll_w-1:0] c_poll_tgt = c_poll_w'(POLL_LIMIT);

    logic [3:0]          r_state, w_next;
    logic                r_gap, r_rd_bit;
    logic [7:0]          r_m_hi, r_m_lo, r_c0_hi, r_c0_lo;
    logic                r_m_odd, r_c0_odd;
    logic                r_lock_meta, r_lock_sync;
    logic [c_poll_w-1:0] r_poll_cnt;
    logic [c_stb_w-1:0]  r_stable_cnt, w_stable_nxt;
    logic [c_tmo_w-1:0]  r_tmo_cnt, w_tmo_nxt;
    logic                r_err;
    logic [1:0]          r_err_code, w_err_code;
    logic                w_err_set, w_accept, w_bus_state, w_strobe_en, w_xfer_done, w_cfg_bad;
    logic                w_unused_rd;

    assign w_unused_rd = ^mgmt_readdata[31:1];

    assign w_accept    = (r_state == c_idle) && start;
    assign w_bus_state = (r_state == c_wr_mode) || (r_state == c_wr_m) || (r_state == c_wr_c) ||
                         (r_state == c_wr_start) || (r_state == c_poll_rd);
    // r_gap is the single idle bus cycle that follows every completed transfer
    assign w_strobe_en = w_bus_state && !r_gap;
    assign mgmt_write  = w_strobe_en && (r_state != c_poll_rd);
    assign mgmt_read   = w_strobe_en && (r_state == c_poll_rd);
    assign w_xfer_done = w_strobe_en && !mgmt_waitrequest;
    assign w_cfg_bad   = (r_m_hi == 8'd0) || (r_m_lo == 8'd0) || (r_c0_hi == 8'd0) || (r_c0_lo == 8'd0);

    assign w_stable_nxt = !r_lock_sync ? '0 :
                          (r_stable_cnt >= c_stb_tgt) ? r_stable_cnt : r_stable_cnt + c_stb_w'(1);
    assign w_tmo_nxt    = (r_tmo_cnt >= c_tmo_tgt) ? r_tmo_cnt : r_tmo_cnt + c_tmo_w'(1);

    assign busy     = (r_state != c_idle) && (r_state != c_done) && (r_state != c_err);
    assign done     = (r_state == c_done);
    assign err      = r_err;
    assign err_code = r_err_code;

    always_comb begin
        mgmt_address   = 6'd0;
        mgmt_writedata = 32'd0;
        if (w_strobe_en) begin
            case (r_state)
                c_wr_mode:  begin mgmt_address = 6'd0; mgmt_writedata = 32'd1; end
                c_wr_m:     begin
                    mgmt_address   = 6'd4;
                    mgmt_writedata = {14'b0, r_m_odd, 1'b0, r_m_hi, r_m_lo};
                end
                c_wr_c:     begin
                    mgmt_address   = 6'd5;
                    mgmt_writedata = {9'b0, 5'd0, r_c0_odd, 1'b0, r_c0_hi, r_c0_lo};
                end
                c_wr_start: mgmt_address = 6'd2;
                c_poll_rd:  mgmt_address = 6'd1;
                default:    ;
            endcase
        end
    end

    always_comb begin
        w_next     = r_state;
        w_err_set  = 1'b0;
        w_err_code = 2'd0;
        case (r_state)
            c_idle:      if (start) w_next = c_check;
            c_check:     if (w_cfg_bad) begin
                             w_next = c_err; w_err_set = 1'b1; w_err_code = 2'd1;
                         end else begin
                             w_next = c_wr_mode;
                         end
            c_wr_mode:   if (r_gap) w_next = c_wr_m;
            c_wr_m:      if (r_gap) w_next = c_wr_c;
            c_wr_c:      if (r_gap) w_next = c_wr_start;
            c_wr_start:  if (r_gap) w_next = c_poll_rd;
            c_poll_rd:   if (r_gap) begin
                             if (r_rd_bit) begin
                                 w_next = c_lock_wait;
                             end else if (r_poll_cnt >= c_poll_tgt) begin
                                 w_next = c_err; w_err_set = 1'b1; w_err_code = 2'd2;
                             end
                         end
            // Stable lock takes priority over a simultaneous timeout
            c_lock_wait: if (w_stable_nxt >= c_stb_tgt) begin
                             w_next = c_done;
                         end else if (w_tmo_nxt >= c_tmo_tgt) begin
                             w_next = c_err; w_err_set = 1'b1; w_err_code = 2'd3;
                         end
            c_done:      w_next = c_idle;
            c_err:       w_next = c_idle;
            default:     w_next = c_idle;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= c_idle;
            r_gap        <= 1'b0;
            r_rd_bit     <= 1'b0;
            r_m_hi       <= 8'd0;
            r_m_lo       <= 8'd0;
            r_m_odd      <= 1'b0;
            r_c0_hi      <= 8'd0;
            r_c0_lo      <= 8'd0;
            r_c0_odd     <= 1'b0;
            r_lock_meta  <= 1'b0;
            r_lock_sync  <= 1'b0;
            r_poll_cnt   <= '0;
            r_stable_cnt <= '0;
            r_tmo_cnt    <= '0;
            r_err        <= 1'b0;
            r_err_code   <= 2'd0;
        end else begin
            r_state     <= w_next;
            r_gap       <= w_xfer_done && (w_next == r_state);
            r_lock_meta <= pll_locked;
            r_lock_sync <= r_lock_meta;
            if (w_xfer_done && mgmt_read) begin
                r_rd_bit <= mgmt_readdata[0];
                if (r_poll_cnt < c_poll_tgt) r_poll_cnt <= r_poll_cnt + c_poll_w'(1);
            end
            if (w_accept) begin
                r_m_hi     <= cfg_m_hi;
                r_m_lo     <= cfg_m_lo;
                r_m_odd    <= cfg_m_odd;
                r_c0_hi    <= cfg_c0_hi;
                r_c0_lo    <= cfg_c0_lo;
                r_c0_odd   <= cfg_c0_odd;
                r_poll_cnt <= '0;
                r_err      <= 1'b0;
                r_err_code <= 2'd0;
            end else if (w_err_set) begin
                r_err      <= 1'b1;
                r_err_code <= w_err_code;
            end
            if (r_state == c_lock_wait) begin
                r_stable_cnt <= w_stable_nxt;
                r_tmo_cnt    <= w_tmo_nxt;
            end else begin
                r_stable_cnt <= '0;
                r_tmo_cnt    <= '0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_nmr_pll_reconfig_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_nmr_pll_reconfig_seq
// Brief    : Randomized self-checking bench with a transaction-level model of
//            the reconfiguration sequence and an Avalon-MM responder.
// Revision : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
module tb_nmr_pll_reconfig_seq;

    localparam int LT = 200;
    localparam int LS = 16;
    localparam int PL = 8;

    logic        clk = 1'b0, reset_n = 1'b0, start = 1'b0;
    logic [7:0]  cfg_m_hi = 8'd0, cfg_m_lo = 8'd0, cfg_c0_hi = 8'd0, cfg_c0_lo = 8'd0;
    logic        cfg_m_odd = 1'b0, cfg_c0_odd = 1'b0, pll_locked = 1'b0;
    logic [5:0]  mgmt_address;
    logic        mgmt_write, mgmt_read;
    logic [31:0] mgmt_writedata;
    logic [31:0] mgmt_readdata = 32'd0;
    logic        mgmt_waitrequest = 1'b0;
    logic        busy, done, err;
    logic [1:0]  err_code;

    nmr_pll_reconfig_seq #(.LOCK_TIMEOUT(LT), .LOCK_STABLE(LS), .POLL_LIMIT(PL)) dut (
        .clk(clk), .reset_n(reset_n), .start(start),
        .cfg_m_hi(cfg_m_hi), .cfg_m_lo(cfg_m_lo), .cfg_m_odd(cfg_m_odd),
        .cfg_c0_hi(cfg_c0_hi), .cfg_c0_lo(cfg_c0_lo), .cfg_c0_odd(cfg_c0_odd),
        .pll_locked(pll_locked),
        .mgmt_address(mgmt_address), .mgmt_write(mgmt_write), .mgmt_read(mgmt_read),
        .mgmt_writedata(mgmt_writedata), .mgmt_readdata(mgmt_readdata),
        .mgmt_waitrequest(mgmt_waitrequest),
        .busy(busy), .done(done), .err(err), .err_code(err_code)
    );

    always #5 clk = ~clk;

    int n_checks = 0, n_errors = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Responder / monitor state
    int   stall_cfg = 0, zeros_cfg = 0, stall_left = 0, rd_count = 0, strobe_cycles = 0, ok_cyc = 0;
    bit   ok_seen = 0, prev_strobe = 0, prev_stalled = 0;
    logic [5:0]  prev_addr = 6'd0;
    logic [31:0] prev_data = 32'd0;
    logic [38:0] txq[$];
    logic [38:0] exp_q[$];
    // Lock waveform relative to the successful poll
    bit sched_en = 0;
    int rise_t = 0, drop_t = 0, drop_len = 0, rise_cyc = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    initial begin : responder
        logic [31:0] rnd;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                mgmt_waitrequest = 1'b0;
                prev_stalled     = 0;
                stall_left       = 0;
            end else if (mgmt_write || mgmt_read) begin
                strobe_cycles++;
                check("rw_excl", {63'd0, mgmt_write & mgmt_read}, 64'd0);
                if (prev_stalled) begin
                    check("stall_addr", {58'd0, mgmt_address}, {58'd0, prev_addr});
                    check("stall_data", {32'd0, mgmt_writedata}, {32'd0, prev_data});
                end
                if (!prev_strobe) stall_left = stall_cfg;
                if (stall_left > 0) begin
                    mgmt_waitrequest = 1'b1;
                    stall_left--;
                end else begin
                    mgmt_waitrequest = 1'b0;
                    if (mgmt_read) begin
                        rnd    = $urandom;
                        rnd[0] = (rd_count >= zeros_cfg);
                        mgmt_readdata = rnd;
                        rd_count++;
                        if (rnd[0]) begin ok_seen = 1; ok_cyc = cyc + 1; end
                        txq.push_back({1'b1, mgmt_address, 32'd0});
                    end else begin
                        txq.push_back({1'b0, mgmt_address, mgmt_writedata});
                    end
                end
                prev_stalled = mgmt_waitrequest;
                prev_addr    = mgmt_address;
                prev_data    = mgmt_writedata;
            end else begin
                mgmt_waitrequest = 1'b0;
                prev_stalled     = 0;
            end
            prev_strobe = mgmt_write | mgmt_read;
        end
    end

    // Transaction model: the sequence a given setting must produce on the bus
    task automatic build_exp(input logic [7:0] mh, ml, input bit mo,
                             input logic [7:0] ch, cl, input bit co, input int zeros);
        int nrd;
        exp_q.delete();
        if (mh == 0 || ml == 0 || ch == 0 || cl == 0) return;
        exp_q.push_back({1'b0, 6'd0, 32'd1});
        exp_q.push_back({1'b0, 6'd4, 32'(mo) * 32'h20000 + 32'(mh) * 32'd256 + 32'(ml)});
        exp_q.push_back({1'b0, 6'd5, 32'(co) * 32'h20000 + 32'(ch) * 32'd256 + 32'(cl)});
        exp_q.push_back({1'b0, 6'd2, 32'd0});
        nrd = (zeros + 1 < PL) ? zeros + 1 : PL;
        for (int i = 0; i < nrd; i++) exp_q.push_back({1'b1, 6'd1, 32'd0});
    endtask

    task automatic do_case(input string nm, input logic [7:0] mh, ml, input bit mo,
                           input logic [7:0] ch, cl, input bit co,
                           input int stall, zeros, input bit lock_ok, input bit dbl,
                           output int fin_cyc, output bit exp_done);
        bit fin, bad;
        int t, n_before;
        logic [1:0] code;
        stall_cfg = stall; zeros_cfg = zeros; rd_count = 0; strobe_cycles = 0; ok_seen = 0;
        txq.delete();
        @(negedge clk);
        cfg_m_hi = mh; cfg_m_lo = ml; cfg_m_odd = mo; cfg_c0_hi = ch; cfg_c0_lo = cl; cfg_c0_odd = co;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check({nm, ".busy_accept"}, {63'd0, busy}, 64'd1);
        check({nm, ".err_clr"}, {62'd0, err, err_code}, 64'd0);
        cfg_m_hi = 8'($urandom); cfg_m_lo = 8'($urandom); cfg_c0_hi = 8'($urandom); cfg_c0_lo = 8'($urandom);
        cfg_m_odd = 1'($urandom); cfg_c0_odd = 1'($urandom);
        fin = 0; fin_cyc = 0;
        for (int i = 0; i < 2000 && !fin; i++) begin
            if (done || err) begin
                fin = 1; fin_cyc = cyc;
            end else begin
                start = (dbl && i == 6);
                if (sched_en && ok_seen) begin
                    t = cyc - ok_cyc;
                    if ((t >= rise_t) && !(t >= drop_t && t < drop_t + drop_len)) begin
                        if (!pll_locked) rise_cyc = cyc + 1;
                        pll_locked = 1'b1;
                    end else begin
                        pll_locked = 1'b0;
                    end
                end
                @(negedge clk);
            end
        end
        start = 1'b0;
        check({nm, ".finished"}, {63'd0, fin}, 64'd1);

        build_exp(mh, ml, mo, ch, cl, co, zeros);
        bad      = (mh == 0 || ml == 0 || ch == 0 || cl == 0);
        code     = bad ? 2'd1 : (zeros >= PL) ? 2'd2 : !lock_ok ? 2'd3 : 2'd0;
        exp_done = (code == 2'd0);
        check({nm, ".tx_count"}, 64'(txq.size()), 64'(exp_q.size()));
        for (int i = 0; i < txq.size() && i < exp_q.size(); i++)
            check($sformatf("%s.tx%0d", nm, i), {25'd0, txq[i]}, {25'd0, exp_q[i]});
        check({nm, ".done"}, {63'd0, done}, {63'd0, exp_done});
        check({nm, ".err"}, {63'd0, err}, {63'd0, !exp_done});
        check({nm, ".err_code"}, {62'd0, err_code}, {62'd0, code});
        check({nm, ".busy_end"}, {63'd0, busy}, 64'd0);
        if (bad) check({nm, ".strobe_cycles"}, 64'(strobe_cycles), 64'd0);
        n_before = txq.size();
        @(negedge clk);
        check({nm, ".done_pulse"}, {63'd0, done}, 64'd0);
        check({nm, ".err_hold"}, {62'd0, err, err_code}, {62'd0, !exp_done, code});
        repeat (4) @(negedge clk);
        check({nm, ".no_extra"}, 64'(txq.size()), 64'(n_before));
    endtask

    task automatic check_outputs_zero(input string nm);
        check({nm, ".addr"}, {58'd0, mgmt_address}, 64'd0);
        check({nm, ".wr_rd"}, {62'd0, mgmt_write, mgmt_read}, 64'd0);
        check({nm, ".wdata"}, {32'd0, mgmt_writedata}, 64'd0);
        check({nm, ".status"}, {59'd0, busy, done, err, err_code}, 64'd0);
    endtask

    function automatic logic [7:0] rnd_cnt();
        return ($urandom_range(0, 9) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
    endfunction

    initial begin : watchdog
        #5_000_000;
        $display("FAIL watchdog: simulation did not reach its end, got timeout expected completion");
        $fatal(1);
    end

    initial begin : main
        int  fin, k_cal, k4;
        bit  ed, seen;
        logic [7:0] a, b, c, d;
        repeat (3) @(negedge clk);
        check_outputs_zero("reset");
        reset_n = 1'b1;
        pll_locked = 1'b1;
        repeat (4) @(negedge clk);

        // T1: nominal retune
        do_case("T1", 8'd5, 8'd4, 1'b1, 8'd2, 8'd2, 1'b0, 0, 0, 1'b1, 1'b0, fin, ed);
        check("T1.lat_win", {63'd0, (fin - ok_cyc >= LS) && (fin - ok_cyc <= LS + 4)}, 64'd1);
        if (txq.size() > 1) check("T1.m_word", {32'd0, txq[1][31:0]}, 64'h0002_0504);

        // T2: stalled transfers
        do_case("T2", 8'd5, 8'd4, 1'b1, 8'd2, 8'd2, 1'b0, 3, 0, 1'b1, 1'b0, fin, ed);

        // T3: slow poll then no lock
        pll_locked = 1'b0;
        do_case("T3", 8'd12, 8'd12, 1'b0, 8'd3, 8'd4, 1'b1, 1, 5, 1'b0, 1'b0, fin, ed);
        check("T3.tmo_win", {63'd0, (fin - ok_cyc >= LT) && (fin - ok_cyc <= LT + 4)}, 64'd1);

        // Lock latency from a clean rising edge
        sched_en = 1; rise_t = 20; drop_t = 1000; drop_len = 0;
        do_case("T4cal", 8'd6, 8'd6, 1'b0, 8'd3, 8'd3, 1'b0, 0, 0, 1'b1, 1'b0, fin, ed);
        k_cal = fin - rise_cyc;
        check("T4cal.lat_win", {63'd0, (k_cal >= LS) && (k_cal <= LS + 4)}, 64'd1);

        // T4: lock glitch restarts stability; second start while busy
        pll_locked = 1'b0;
        rise_t = 5; drop_t = 12; drop_len = 3;
        do_case("T4", 8'd6, 8'd6, 1'b0, 8'd3, 8'd3, 1'b0, 0, 0, 1'b1, 1'b1, fin, ed);
        k4 = fin - rise_cyc;
        check("T4.relock_lat", 64'(k4), 64'(k_cal));
        sched_en = 0;
        pll_locked = 1'b1;

        // Poll limit exhausted
        do_case("PLIM", 8'd9, 8'd1, 1'b1, 8'd7, 8'd8, 1'b0, 2, 20, 1'b1, 1'b0, fin, ed);

        // T5: bad config
        do_case("T5", 8'd2, 8'd2, 1'b0, 8'd2, 8'd0, 1'b0, 0, 0, 1'b1, 1'b0, fin, ed);

        // Reset in the middle of polling
        zeros_cfg = 100; stall_cfg = 0; rd_count = 0;
        @(negedge clk);
        cfg_m_hi = 8'd3; cfg_m_lo = 8'd3; cfg_c0_hi = 8'd3; cfg_c0_lo = 8'd3;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        seen = 0;
        for (int i = 0; i < 200 && !seen; i++) begin
            if (mgmt_read) seen = 1;
            else @(negedge clk);
        end
        check("RST.read_seen", {63'd0, seen}, 64'd1);
        reset_n = 1'b0;
        #1;
        check_outputs_zero("RST");
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        repeat (4) @(negedge clk);
        do_case("T5rst", 8'd5, 8'd4, 1'b1, 8'd2, 8'd2, 1'b0, 0, 0, 1'b1, 1'b0, fin, ed);
        check("T5rst.lat_win", {63'd0, (fin - ok_cyc >= LS) && (fin - ok_cyc <= LS + 4)}, 64'd1);

        // Randomized settings, stalls and poll lengths
        for (int n = 0; n < 12; n++) begin
            a = rnd_cnt(); b = rnd_cnt(); c = rnd_cnt(); d = rnd_cnt();
            do_case($sformatf("R%0d", n), a, b, 1'($urandom), c, d, 1'($urandom),
                    $urandom_range(0, 3), $urandom_range(0, 9), 1'b1, 1'($urandom), fin, ed);
            if (ed) check($sformatf("R%0d.lat_win", n),
                          {63'd0, (fin - ok_cyc >= LS) && (fin - ok_cyc <= LS + 4)}, 64'd1);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
